y86_dmem_responder: RTL and testbench

- Data-memory responder for the pipelined Y86-64 core: the memory-side end of the Memory stage's load/store interface.
- Accepts one 8-byte read or write request at a time over a valid/ready handshake.
- Models a configurable access latency, performs little-endian byte-addressed access, and returns read data plus an error flag. The error flag feeds the core's data-memory-error status (stat = ADR).

---
 rtl/y86_dmem_responder.sv | 139 +++++++++++++
 tb/tb_y86_dmem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/y86_dmem_responder.sv
// Data-memory responder for the Y86-64 Memory stage: one 8-byte little-endian load/store at a time
// with a fixed access latency. Define Y86_DMEM_ALIGN_CHECK_EN to also flag addr[2:0] != 0 as an error.
module y86_dmem_responder #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);
  localparam int IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_write;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;
  logic [63:0]      r_wdata;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_busy;
  logic [63:0]      r_rdata;
  logic [7:0]       r_mem [MEM_BYTES];

  logic             w_req_err;
  logic             w_do_access;
  logic             w_acc_write;
  logic             w_acc_err;
  logic [IDX_W-1:0] w_acc_idx;
  logic [63:0]      w_acc_wdata;
  logic [63:0]      w_rd_word;
  logic [IDX_W-1:0] w_idx [8];

  // Range check at full address width so addresses near 2^64 cannot wrap into range.
`ifdef Y86_DMEM_ALIGN_CHECK_EN
  assign w_req_err = (req_addr > ADDR_W'(MEM_BYTES - 8)) || (req_addr[2:0] != 3'b000);
`else
  assign w_req_err = (req_addr > ADDR_W'(MEM_BYTES - 8));
`endif

  // With zero latency the access happens on the accepting edge, straight from the request inputs.
  assign w_do_access = rst_n &&
                       (((LATENCY == 0) && (r_state == IDLE) && req_valid) ||
                        ((r_state == WAIT) && (r_cnt == 4'd0)));
  assign w_acc_write = (r_state == IDLE) ? req_write               : r_write;
  assign w_acc_err   = (r_state == IDLE) ? w_req_err               : r_err;
  assign w_acc_idx   = (r_state == IDLE) ? req_addr[IDX_W-1:0]     : r_idx;
  assign w_acc_wdata = (r_state == IDLE) ? req_wdata               : r_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_byte
      assign w_idx[gi]              = w_acc_idx + IDX_W'(gi);
      assign w_rd_word[8*gi +: 8]   = r_mem[w_idx[gi]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_do_access && w_acc_write && !w_acc_err) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[w_idx[k]] <= w_acc_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_write     <= 1'b0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 64'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_rdata     <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_idx       <= req_addr[IDX_W-1:0];
            r_wdata     <= req_wdata;
            r_err       <= w_req_err;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= RESP;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Response fields are loaded only on the edge that enters RESP, so they hold under backpressure.
      if (w_do_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= w_acc_err;
        r_rdata     <= (w_acc_write || w_acc_err) ? 64'd0 : w_rd_word;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
endmodule

// File: tb/tb_y86_dmem_responder.sv
// Directed bench for y86_dmem_responder: table of load/store vectors on a LATENCY=2 instance plus
// hand sequences for backpressure, mid-operation reset and a LATENCY=0 instance.
module tb_y86_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [63:0] rsp_rdata;

  logic        req_valid_z = 1'b0, req_write_z = 1'b0, rsp_ready_z = 1'b0;
  logic [63:0] req_addr_z = 64'd0, req_wdata_z = 64'd0;
  logic        req_ready_z, rsp_valid_z, rsp_err_z, busy_z;
  logic [63:0] rsp_rdata_z;

  int n_vec = 0;
  int n_bad = 0;

`ifdef Y86_DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  always #5 clk = ~clk;

  y86_dmem_responder #(.MEM_BYTES(1024), .LATENCY(2), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  y86_dmem_responder #(.MEM_BYTES(1024), .LATENCY(0), .ADDR_W(64)) dut_z (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_write(req_write_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_rdata(rsp_rdata_z),
    .rsp_err(rsp_err_z), .busy(busy_z)
  );

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request on the LATENCY=2 instance; lat counts edges from acceptance to rsp_valid.
  task automatic run_req(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         output logic [63:0] rd, output logic er, output int lat);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;

    vecs[0]  = '{1'b1, 64'h18, 64'h0, 64'h0, 1'b0};
    vecs[1]  = '{1'b1, 64'h10, 64'h0123456789ABCDEF, 64'h0, 1'b0};
    vecs[2]  = '{1'b0, 64'h10, 64'h0, 64'h0123456789ABCDEF, 1'b0};
    vecs[3]  = '{1'b0, 64'h11, 64'h0, ALIGN ? 64'h0 : 64'h000123456789ABCD, ALIGN};
    vecs[4]  = '{1'b1, 64'h3F8, 64'h1122334455667788, 64'h0, 1'b0};
    vecs[5]  = '{1'b0, 64'h3F8, 64'h0, 64'h1122334455667788, 1'b0};
    vecs[6]  = '{1'b0, 64'h3F9, 64'h0, 64'h0, 1'b1};
    vecs[7]  = '{1'b1, 64'hFFFFFFFFFFFFFFF9, 64'hDEADBEEFDEADBEEF, 64'h0, 1'b1};
    vecs[8]  = '{1'b0, 64'h3F8, 64'h0, 64'h1122334455667788, 1'b0};
    vecs[9]  = '{1'b1, 64'h400, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1};
    vecs[10] = '{1'b1, 64'h20, 64'h0, 64'h0, 1'b0};
    vecs[11] = '{1'b0, 64'h14, 64'h0, ALIGN ? 64'h0 : 64'h0000000001234567, ALIGN};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_req_ready", {63'd0, req_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_rsp_err",   {63'd0, rsp_err}, 64'd0);
    chk("reset_busy",      {63'd0, busy}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_req(vecs[i].write, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      $display("vec %0d: %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
               i, vecs[i].write ? "WR" : "RD", vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
    end

    // Backpressure: response held for 5 cycles while an ignored store is presented.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h3F8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", 64'(lat), 64'd3);
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h3F8; req_wdata = 64'h0;
      @(posedge clk); #1;
      chk("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_rsp_rdata", rsp_rdata, 64'h1122334455667788);
      chk("bp_rsp_err",   {63'd0, rsp_err}, 64'd0);
      chk("bp_req_ready", {63'd0, req_ready}, 64'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_release_req_ready", {63'd0, req_ready}, 64'd1);
    chk("bp_release_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("bp_release_busy",      {63'd0, busy}, 64'd0);
    chk("bp_release_rdata_kept", rsp_rdata, 64'h1122334455667788);
    $display("backpressure: held 5 cycles, released");
    run_req(1'b0, 64'h3F8, 64'h0, rd, er, lat);
    chk("bp_ignored_store", rd, 64'h1122334455667788);

    // Reset during WAIT discards the pending store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'hAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midrst_busy_wait", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("midrst_busy",      {63'd0, busy}, 64'd0);
    chk("midrst_rsp_err",   {63'd0, rsp_err}, 64'd0);
    chk("midrst_rsp_rdata", rsp_rdata, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    run_req(1'b0, 64'h20, 64'h0, rd, er, lat);
    $display("midreset: read 0x20 -> %h err=%0d", rd, er);
    chk("midrst_mem_unchanged", rd, 64'd0);

    // LATENCY=0 instance: response next cycle, next accept two cycles after the first.
    req_valid_z = 1'b1; req_write_z = 1'b1; req_addr_z = 64'h40;
    req_wdata_z = 64'hCAFEF00D12345678; rsp_ready_z = 1'b1;
    @(posedge clk); #1;
    chk("lat0_wr_rsp_valid", {63'd0, rsp_valid_z}, 64'd1);
    chk("lat0_wr_err",       {63'd0, rsp_err_z}, 64'd0);
    chk("lat0_wr_req_ready", {63'd0, req_ready_z}, 64'd0);
    req_write_z = 1'b0;
    @(posedge clk); #1;
    chk("lat0_exit_rsp_valid", {63'd0, rsp_valid_z}, 64'd0);
    chk("lat0_exit_req_ready", {63'd0, req_ready_z}, 64'd1);
    @(posedge clk); #1;
    req_valid_z = 1'b0;
    chk("lat0_rd_rsp_valid", {63'd0, rsp_valid_z}, 64'd1);
    chk("lat0_rd_rdata",     rsp_rdata_z, 64'hCAFEF00D12345678);
    $display("lat0: write then read 0x40 -> %h", rsp_rdata_z);
    @(posedge clk); #1;
    rsp_ready_z = 1'b0;
    chk("lat0_idle_req_ready", {63'd0, req_ready_z}, 64'd1);
    chk("lat0_idle_busy",      {63'd0, busy_z}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
